// File: rtl/clk_gen.sv
// ---------------------------------------------------------------------------
// clk_gen -- programmable clock generator / divider
//
// Produces a registered, glitch-free divided clock gen_clk from clk, together
// with one-cycle rise/fall strobes for logic that stays in the clk domain.
// gen_clk is high for ceil(N/2) cycles and low for the remaining N-ceil(N/2)
// cycles of every N-cycle period.
//
// Ports:
//   clk       in   system clock, rising edge only
//   reset     in   asynchronous, active-low reset
//   en        in   run enable; sampled at start and at every period boundary
//   div       in   requested division ratio N (0 and 1 are treated as 2)
//   div_load  in   captures div into the pending-ratio register
//   gen_clk   out  generated clock, straight from a flop
//   gen_rise  out  high in the cycle gen_clk first reads 1
//   gen_fall  out  high in the cycle gen_clk first reads 0
//   running   out  high while a generated period is in progress
// ---------------------------------------------------------------------------
module clk_gen #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 div_load,
    output logic                 gen_clk,
    output logic                 gen_rise,
    output logic                 gen_fall,
    output logic                 running
);

    localparam logic [DIV_WIDTH-1:0] DEF_RATIO = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] MIN_RATIO = DIV_WIDTH'(2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] ratio;     // active N, only changes at a boundary
    logic [DIV_WIDTH-1:0] pending;   // last loaded N, waiting for a boundary
    logic [DIV_WIDTH-1:0] div_clamped;
    logic [DIV_WIDTH:0]   high_len;  // ceil(N/2); one extra bit for N+1
    logic [DIV_WIDTH:0]   cnt_inc;
    logic                 wrap;
    logic                 clk_nxt;

    // Ratios below 2 cannot produce both a high and a low phase.
    assign div_clamped = (div < MIN_RATIO) ? MIN_RATIO : div;

    assign high_len = ({1'b0, ratio} + (DIV_WIDTH+1)'(1)) >> 1;
    assign cnt_inc  = {1'b0, cnt} + (DIV_WIDTH+1)'(1);
    assign wrap     = (cnt == ratio - DIV_WIDTH'(1));

    // Next gen_clk value. The strobes are derived from this and the current
    // flop so that they line up with the cycle the new level appears.
    always_comb begin
        clk_nxt = 1'b0;
        case (state)
            IDLE: clk_nxt = en;
            RUN:  clk_nxt = wrap ? en : (cnt_inc < high_len);
            default: clk_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ratio    <= DEF_RATIO;
            pending  <= DEF_RATIO;
            gen_clk  <= 1'b0;
            gen_rise <= 1'b0;
            gen_fall <= 1'b0;
            running  <= 1'b0;
        end else begin
            // The boundary below reads the old pending value, so a load on
            // the boundary edge lands in the period after the next one.
            if (div_load)
                pending <= div_clamped;

            gen_clk  <= clk_nxt;
            gen_rise <= clk_nxt & ~gen_clk;
            gen_fall <= ~clk_nxt & gen_clk;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state   <= RUN;
                        running <= 1'b1;
                        ratio   <= pending;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        cnt <= '0;
                        if (en) begin
                            ratio <= pending;
                        end else begin
                            // Period finished cleanly; gen_clk is already low.
                            state   <= IDLE;
                            running <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_inc[DIV_WIDTH-1:0];
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gen.sv
module tb_clk_gen;

    localparam int DW  = 8;
    localparam int DEF = 2;

    logic          clk;
    logic          reset;
    logic          en;
    logic [DW-1:0] div;
    logic          div_load;
    logic          gen_clk, gen_rise, gen_fall, running;

    clk_gen #(.DIV_WIDTH(DW), .DEFAULT_DIV(DEF)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div      (div),
        .div_load (div_load),
        .gen_clk  (gen_clk),
        .gen_rise (gen_rise),
        .gen_fall (gen_fall),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model: a queue holding the gen_clk waveform still owed for the
    // current period. An empty queue at an edge is a period boundary / idle.
    bit q[$];
    int m_n, m_pend;
    bit m_clk, m_rise, m_fall, m_run;

    task automatic model_reset();
        q.delete();
        m_n = DEF; m_pend = DEF;
        m_clk = 0; m_rise = 0; m_fall = 0; m_run = 0;
    endtask

    task automatic model_edge(input bit e, input bit dl, input int d);
        bit prev;
        int h;
        prev = m_clk;
        if (q.size() == 0 && e) begin
            m_n = m_pend;
            h = (m_n + 1) / 2;
            for (int i = 0; i < m_n; i++) q.push_back(i < h);
        end
        if (q.size() != 0) begin
            m_clk = q.pop_front();
            m_run = 1;
        end else begin
            m_clk = 0;
            m_run = 0;
        end
        m_rise = m_clk & ~prev;
        m_fall = ~m_clk & prev;
        if (dl) m_pend = (d < 2) ? 2 : d;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".gen_clk"},  gen_clk,  m_clk);
        chk({tag, ".gen_rise"}, gen_rise, m_rise);
        chk({tag, ".gen_fall"}, gen_fall, m_fall);
        chk({tag, ".running"},  running,  m_run);
    endtask

    // One clk edge: inputs are stable, sample #1 after the edge.
    task automatic step(input string tag);
        bit e, dl;
        int d;
        e = en; dl = div_load; d = int'(div);
        @(posedge clk);
        #1;
        cyc++;
        model_edge(e, dl, d);
        chk_all(tag);
    endtask

    task automatic load(input int v, input string tag);
        div = DW'(v);
        div_load = 1'b1;
        step(tag);
        div_load = 1'b0;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic timeout_chk(input string tag, input bit ok);
        checks++;
        assert (ok) else begin
            fails++;
            $error("FAIL %s observed=timeout expected=condition reached", tag);
        end
    endtask

    initial begin
        bit ok;
        reset = 1'b0; en = 1'b0; div = '0; div_load = 1'b0;
        model_reset();
        #3;
        chk_all("reset");
        @(posedge clk); #1;
        chk_all("reset_hold");

        // Release with en=1, default N=2.
        en = 1'b1;
        reset = 1'b1;
        run(8, "n2");

        // Load 5 mid-period at N=2.
        load(5, "load5");
        run(16, "n5");

        // Ratios 0 and 1 behave as 2.
        load(0, "load0");
        run(10, "n0");
        load(1, "load1");
        run(10, "n1");

        // N=6, drop en at cnt=1.
        load(6, "load6");
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step("wait6");
            ok = (m_n == 6 && q.size() == 4);
        end
        timeout_chk("wait_n6_cnt1", ok);
        en = 1'b0;
        run(12, "en_drop");

        // Two loads in one period: 3 then 7, only 7 is applied.
        en = 1'b1;
        run(2, "restart");
        load(3, "load3");
        load(7, "load7");
        run(20, "n7");

        // Async reset in the high phase of an N=7 period.
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step("wait7hi");
            ok = (m_n == 7 && m_clk == 1 && q.size() == 5);
        end
        timeout_chk("wait_n7_high", ok);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        #3;
        reset = 1'b1;
        run(8, "after_reset");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 15) != 0);
            div_load = ($urandom_range(0, 6) == 0);
            div      = DW'($urandom_range(0, 12));
            step("rand");
        end
        div_load = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/clk_gen.md
Name: clk_gen

Overview:
- Programmable clock generator/divider. Derives a registered, glitch-free clock `gen_clk` from the system clock `clk`.
- Also produces one-cycle edge strobes for logic that stays in the `clk` domain.
- Serves as the clock source for downstream pulse and divider blocks, such as the divide-by-5 pulse generator.

Parameters:
- DIV_WIDTH, 8, width of the division-ratio input and internal counter.
- DEFAULT_DIV, 2, division ratio loaded at reset; must be >= 2 and < 2^DIV_WIDTH.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  run enable.
- div  input  DIV_WIDTH  requested division ratio N.
- div_load  input  1  strobe that captures `div` into the pending-ratio register.
- gen_clk  output  1  generated clock, driven directly from a flop.
- gen_rise  output  1  high for one `clk` cycle in the cycle `gen_clk` is 1 after being 0.
- gen_fall  output  1  high for one `clk` cycle in the cycle `gen_clk` is 0 after being 1.
- running  output  1  high while a generated period is in progress.

Behaviour:
- Reset (reset=0, asynchronous): gen_clk=0, gen_rise=0, gen_fall=0, running=0, cnt=0, active ratio=DEFAULT_DIV, pending ratio=DEFAULT_DIV.
- Ratio clamp: a `div` value of 0 or 1 is stored as 2.
- Pending ratio:
  - div_load=1 captures the clamped `div` into the pending register.
  - The latest load wins.
  - The active ratio N takes the pending value only at a period boundary (cnt wrap) or at a start from idle. A mid-period load never shortens or stretches the current period.
- High phase length: H = ceil(N/2) cycles; low phase = N - H cycles.
- Idle state (running=0):
  - gen_clk is held at 0.
  - On an edge with en=1: running<=1, cnt<=0, gen_clk<=1, gen_rise<=1, and N<=pending.
- Running state, each edge:
  - If cnt=N-1 (wrap):
    - If en=1: cnt<=0, N<=pending, gen_clk<=1.
    - Else: running<=0, cnt<=0, gen_clk<=0.
  - Otherwise: cnt<=cnt+1 and gen_clk<=(cnt+1 < H).
- Edge strobes: gen_rise and gen_fall are registered with gen_clk, so they are asserted in the same cycle the new gen_clk value appears. They are never both high.
- en dropping mid-period: the current period completes in full, then the block idles with gen_clk=0. gen_clk never produces a runt pulse.
- Examples:
  - N=2: gen_clk toggles every `clk` cycle (1,0,1,0...).
  - N=5: pattern 1,1,1,0,0, repeating.
- Reset asserted mid-period: all outputs go to 0 immediately (asynchronous). Operation restarts from idle after release.
- Clean outputs: no combinational path from any input to gen_clk, gen_rise, gen_fall or running. gen_clk is never derived by gating `clk`.

Test Plan:
- Reset release with en=1 and default N=2:
  - gen_clk = 1,0,1,0... from the first edge after release.
  - gen_rise high on odd cycles; gen_fall high on even cycles.
  - running=1.
- Load div=5 while running at N=2: the new ratio applies only after the current period ends, then gen_clk repeats 1,1,1,0,0 with exactly one gen_rise per 5 cycles.
- div=0 or div=1 loaded: behaves exactly as N=2.
- en deasserted in cnt=1 of an N=6 period:
  - gen_clk completes 1,1,1,0,0,0.
  - Then gen_clk and running stay 0; no gen_rise follows.
- reset asserted asynchronously mid-high-phase:
  - gen_clk, gen_rise, gen_fall and running drop to 0 without waiting for a `clk` edge.
  - After release with en=1, gen_clk restarts with N=DEFAULT_DIV.
- Two div_load strobes in one period (div=3, then div=7): the next period uses 7 (1,1,1,1,0,0,0); 3 is never applied.
